// File: rtl/mod_mul_pkg.sv
// Shared constants for the modular-multiplier cluster.
//   Q_LEN / E_LEN : operand and exponent widths
//   R             : log2 of the multiplier's reduction radix
//   MUL_LAT_DEF   : default multiplier latency (operands -> mul_c)
//   ST_*          : mod_exp_ctrl state encoding
package mod_mul_pkg;
   localparam int Q_LEN       = 64;
   localparam int R           = 64;
   localparam int E_LEN       = 64;
   localparam int MUL_LAT_DEF = 9;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SQR  = 2'd1;
   localparam logic [1:0] ST_MUL  = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;
endpackage

// File: rtl/mod_exp_ctrl_msb_index.sv
// msb_index: combinational priority encoder, returns the position of the
// highest set bit of vec_i (0 when vec_i is 0 or 1).
//   vec_i : E_LEN-bit input vector
//   idx_o : clog2(E_LEN)-bit index of the most significant one
module msb_index #(
   parameter int E_LEN = 64,
   parameter int IW    = $clog2(E_LEN)
) (
   input  logic [E_LEN-1:0] vec_i,
   output logic [IW-1:0]    idx_o
);
   // Ascending scan: the last hit wins, so the highest set bit is kept.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < E_LEN; i++) begin
         if (vec_i[i]) idx_o = IW'(i);
      end
   end
endmodule

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer wrapped around
// an external pipelined modular multiplier.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begin exponentiation (accepted in IDLE only)
//   base, exp, one  : operands, latched with start; one = domain's 1
//   busy, done      : not-IDLE flag, one-cycle completion strobe
//   result          : final value, held until the next completion
//   mul_a, mul_b    : registered multiplier operands
//   mul_issue       : strobe in the first cycle of each multiplication
//   mul_c           : multiplier output, sampled MUL_LAT cycles after issue
module mod_exp_ctrl #(
   parameter int Q_LEN   = mod_mul_pkg::Q_LEN,
   parameter int E_LEN   = mod_mul_pkg::E_LEN,
   parameter int MUL_LAT = mod_mul_pkg::MUL_LAT_DEF,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [Q_LEN-1:0] base,
   input  logic [E_LEN-1:0] exp,
   input  logic [Q_LEN-1:0] one,
   output logic             busy,
   output logic             done,
   output logic [Q_LEN-1:0] result,
   output logic [Q_LEN-1:0] mul_a,
   output logic [Q_LEN-1:0] mul_b,
   output logic             mul_issue,
   input  logic [Q_LEN-1:0] mul_c
);
   import mod_mul_pkg::*;

   localparam int IW = $clog2(E_LEN);

   logic [1:0]       state_q, state_d;
   logic [Q_LEN-1:0] acc_q, acc_d;
   logic [Q_LEN-1:0] base_q, base_d;
   logic [E_LEN-1:0] exp_q, exp_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [Q_LEN-1:0] result_q, result_d;
   logic [Q_LEN-1:0] mul_a_q, mul_a_d;
   logic [Q_LEN-1:0] mul_b_q, mul_b_d;
   logic             done_q, done_d;
   logic             issue_q, issue_d;

   logic [IW-1:0]    msb_idx;
   logic [IW-1:0]    idx_m1;
   logic             exp_le1;

   msb_index #(.E_LEN(E_LEN), .IW(IW)) u_msb (
      .vec_i (exp),
      .idx_o (msb_idx)
   );

   assign idx_m1  = idx_q - IW'(1);
   assign exp_le1 = ~|exp[E_LEN-1:1];

   // done, result, mul_issue and operands are loaded on the edge that
   // enters the corresponding state, so they are valid in that state's
   // first cycle without any combinational path to the outputs.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      base_d   = base_q;
      exp_d    = exp_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      done_d   = 1'b0;
      issue_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d = base;
               exp_d  = exp;
               idx_d  = msb_idx;
               cnt_d  = '0;
               acc_d  = (exp == '0) ? one : base;
               if (exp_le1) begin
                  state_d  = ST_FIN;
                  done_d   = 1'b1;
                  result_d = acc_d;
               end else begin
                  state_d = ST_SQR;
                  mul_a_d = base;
                  mul_b_d = base;
                  issue_d = 1'b1;
               end
            end
         end
         ST_SQR, ST_MUL: begin
            if (cnt_q == CNT_W'(MUL_LAT)) begin
               acc_d = mul_c;
               cnt_d = '0;
               // A set exponent bit keeps idx so the multiply consumes it.
               if (state_q == ST_SQR && exp_q[idx_m1]) begin
                  state_d = ST_MUL;
                  mul_a_d = mul_c;
                  mul_b_d = base_q;
                  issue_d = 1'b1;
               end else begin
                  idx_d = idx_m1;
                  if (idx_m1 == '0) begin
                     state_d  = ST_FIN;
                     done_d   = 1'b1;
                     result_d = mul_c;
                  end else begin
                     state_d = ST_SQR;
                     mul_a_d = mul_c;
                     mul_b_d = mul_c;
                     issue_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         base_q   <= '0;
         exp_q    <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         done_q   <= 1'b0;
         issue_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         done_q   <= done_d;
         issue_q  <= issue_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign result    = result_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_issue = issue_q;
endmodule
